// File: rtl/midi_message_decoder_pkg.sv
// midi_message_decoder_pkg: shared MIDI types for the decoder and voice pipeline
//   note_change_t : {status ON/OFF, note_number[6:0], velocity[6:0]}
//   status-type constants and the decoder state enum
package MIDI;
    localparam int DATA_WIDTH = 7;
    typedef enum logic {
        OFF = 1'b0,
        ON  = 1'b1
    } note_status_t;
    typedef struct packed {
        note_status_t          status;
        logic [DATA_WIDTH-1:0] note_number;
        logic [DATA_WIDTH-1:0] velocity;
    } note_change_t;
    localparam logic [3:0] NOTE_OFF         = 4'h8;
    localparam logic [3:0] NOTE_ON          = 4'h9;
    localparam logic [3:0] CONTROL_CHANGE   = 4'hB;
    localparam logic [3:0] PROGRAM_CHANGE   = 4'hC;
    localparam logic [3:0] CHANNEL_PRESSURE = 4'hD;
    localparam logic [7:0] SYSEX_START      = 8'hF0;
    localparam logic [7:0] SYSEX_END        = 8'hF7;
    localparam logic [7:0] REALTIME_MIN     = 8'hF8;
    typedef enum logic [1:0] {
        IDLE,
        DATA1,
        DATA2,
        SYSEX
    } dec_state_t;
    function automatic logic is_two_byte(input logic [3:0] msg_type);
        return !(msg_type == PROGRAM_CHANGE || msg_type == CHANNEL_PRESSURE);
    endfunction
endpackage

// File: rtl/midi_message_decoder.sv
// midi_message_decoder: MIDI byte stream -> note change / control change events
//   clock_50_000_000, reset (sync, active-high)
//   byte_data[7:0], byte_valid : received byte and its one-cycle strobe
//   note, note_ready           : last note message and its update pulse
//   cc_number, cc_value, cc_ready : last control change and its update pulse
//   MIDI_OMNI_EN defined: accept all channels; otherwise only CHANNEL is emitted
module midi_message_decoder
    import MIDI::*;
#(
    parameter int CHANNEL = 0
) (
    input  logic               clock_50_000_000,
    input  logic               reset,
    input  logic [7:0]         byte_data,
    input  logic               byte_valid,
    output MIDI::note_change_t note,
    output logic               note_ready,
    output logic [6:0]         cc_number,
    output logic [6:0]         cc_value,
    output logic               cc_ready
);
    dec_state_t   state, state_next;
    logic [7:0]   running_status, running_status_next;
    logic [6:0]   data1, data1_next;
    note_change_t note_next;
    logic         note_ready_next, cc_ready_next;
    logic [6:0]   cc_number_next, cc_value_next;
    logic [3:0]   msg_type;
    logic         channel_ok, status_byte, data_byte;

    assign msg_type    = running_status[7:4];
    // realtime bytes fall through both classes and leave everything untouched
    assign status_byte = byte_valid && byte_data[7] && byte_data < REALTIME_MIN;
    assign data_byte   = byte_valid && !byte_data[7];
`ifdef MIDI_OMNI_EN
    assign channel_ok  = 1'b1;
`else
    assign channel_ok  = running_status[3:0] == 4'(CHANNEL);
`endif

    always_ff @(posedge clock_50_000_000) begin
        if (reset) begin
            state          <= IDLE;
            running_status <= '0;
            data1          <= '0;
            note           <= '0;
            note_ready     <= 1'b0;
            cc_number      <= '0;
            cc_value       <= '0;
            cc_ready       <= 1'b0;
        end else begin
            state          <= state_next;
            running_status <= running_status_next;
            data1          <= data1_next;
            note           <= note_next;
            note_ready     <= note_ready_next;
            cc_number      <= cc_number_next;
            cc_value       <= cc_value_next;
            cc_ready       <= cc_ready_next;
        end
    end

    always_comb begin
        state_next          = state;
        running_status_next = running_status;
        data1_next          = data1;
        note_next           = note;
        note_ready_next     = 1'b0;
        cc_number_next      = cc_number;
        cc_value_next       = cc_value;
        cc_ready_next       = 1'b0;
        if (status_byte) begin
            // channel status latches running status; system common clears it
            running_status_next = (byte_data < SYSEX_START) ? byte_data : 8'h00;
            state_next = (byte_data < SYSEX_START) ? DATA1 :
                         (byte_data == SYSEX_START) ? SYSEX : IDLE;
        end else if (data_byte && state == DATA1) begin
            data1_next = byte_data[6:0];
            state_next = is_two_byte(msg_type) ? DATA2 : DATA1;
        end else if (data_byte && state == DATA2) begin
            state_next = DATA1;
            if (channel_ok && (msg_type == NOTE_ON || msg_type == NOTE_OFF)) begin
                note_next = '{
                    status:      (msg_type == NOTE_ON && byte_data[6:0] != 7'd0) ? ON : OFF,
                    note_number: data1,
                    velocity:    byte_data[6:0]
                };
                note_ready_next = 1'b1;
            end
            if (channel_ok && msg_type == CONTROL_CHANGE) begin
                cc_number_next = data1;
                cc_value_next  = byte_data[6:0];
                cc_ready_next  = 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_midi_message_decoder.sv
// tb_midi_message_decoder: directed vector bench for midi_message_decoder
module tb_midi_message_decoder;
    import MIDI::*;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [7:0]   byte_data = '0;
    logic         byte_valid = 1'b0;
    note_change_t note;
    logic         note_ready, cc_ready;
    logic [6:0]   cc_number, cc_value;

    int checks = 0;
    int failures = 0;

    always #10 clk = ~clk;

    midi_message_decoder #(.CHANNEL(0)) dut (
        .clock_50_000_000(clk),
        .reset(reset),
        .byte_data(byte_data),
        .byte_valid(byte_valid),
        .note(note),
        .note_ready(note_ready),
        .cc_number(cc_number),
        .cc_value(cc_value),
        .cc_ready(cc_ready)
    );

    // expected = {note_ready, note[14:0], cc_ready, cc_number, cc_value}
    typedef struct {
        logic        rst;
        logic        vld;
        logic [7:0]  b;
        logic [30:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [14:0] hn;
    logic [13:0] hc;

    function automatic logic [14:0] nt(input logic on, input int n, input int v);
        return {on, 7'(n), 7'(v)};
    endfunction

    function automatic void add(input logic rst, input logic vld, input logic [7:0] b,
                                input logic nr, input logic cr);
        vec_t r;
        r.rst = rst;
        r.vld = vld;
        r.b   = b;
        r.exp = {nr, hn, cr, hc};
        vecs.push_back(r);
    endfunction

    task automatic step(input logic r, input logic v, input logic [7:0] b);
        @(negedge clk);
        reset      = r;
        byte_valid = v;
        byte_data  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [30:0] act, input logic [30:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    initial begin
        logic omni;
`ifdef MIDI_OMNI_EN
        omni = 1'b1;
`else
        omni = 1'b0;
`endif
        hn = '0;
        hc = '0;
        add(1, 0, 8'h00, 0, 0);
        add(0, 1, 8'h90, 0, 0);
        add(0, 1, 8'h3C, 0, 0);
        hn = nt(1, 60, 100);
        add(0, 1, 8'h64, 1, 0);
        add(0, 0, 8'h00, 0, 0);
        add(0, 1, 8'h40, 0, 0);
        hn = nt(0, 64, 0);
        add(0, 1, 8'h00, 1, 0);
        add(0, 1, 8'h3C, 0, 0);
        add(0, 1, 8'hF8, 0, 0);
        hn = nt(1, 60, 100);
        add(0, 1, 8'h64, 1, 0);
        add(0, 1, 8'hF0, 0, 0);
        add(0, 1, 8'h7E, 0, 0);
        add(0, 1, 8'h01, 0, 0);
        add(0, 1, 8'hF7, 0, 0);
        add(0, 1, 8'h3C, 0, 0);
        add(0, 1, 8'h40, 0, 0);
        add(0, 1, 8'h91, 0, 0);
        add(0, 1, 8'h3C, 0, 0);
        add(0, 1, 8'h64, omni, 0);
        add(0, 1, 8'hB0, 0, 0);
        add(0, 1, 8'h07, 0, 0);
        hc = {7'd7, 7'd127};
        add(0, 1, 8'h7F, 0, 1);
        add(0, 1, 8'h90, 0, 0);
        add(0, 1, 8'h3C, 0, 0);
        hn = '0;
        hc = '0;
        add(1, 0, 8'h00, 0, 0);
        add(0, 1, 8'h64, 0, 0);
        add(0, 1, 8'h80, 0, 0);
        add(0, 1, 8'h45, 0, 0);
        hn = nt(0, 69, 51);
        add(0, 1, 8'h33, 1, 0);
        add(0, 1, 8'h90, 0, 0);
        add(0, 1, 8'h30, 0, 0);
        add(0, 1, 8'hB0, 0, 0);
        add(0, 1, 8'h10, 0, 0);
        hc = {7'd16, 7'd32};
        add(0, 1, 8'h20, 0, 1);
        add(0, 1, 8'hC0, 0, 0);
        add(0, 1, 8'h05, 0, 0);
        add(0, 1, 8'h06, 0, 0);
        add(0, 1, 8'hF0, 0, 0);
        add(0, 1, 8'h12, 0, 0);
        add(0, 1, 8'h90, 0, 0);
        add(0, 1, 8'h24, 0, 0);
        hn = nt(1, 36, 127);
        add(0, 1, 8'h7F, 1, 0);
        add(0, 0, 8'h00, 0, 0);

        step(1, 0, 8'h00);
        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].vld, vecs[i].b);
            chk($sformatf("vec%0d_b%02h", i, vecs[i].b),
                {note_ready, note, cc_ready, cc_number, cc_value}, vecs[i].exp);
        end

        // running-status CC burst with back-to-back emits, then a silent pitch bend
        step(1, 0, 8'h00);
        chk("hs_reset", {note_ready, note, cc_ready, cc_number, cc_value}, 31'd0);
        step(0, 1, 8'hB0);
        step(0, 1, 8'h01);
        chk("hs_cc_d1", {15'd0, note_ready, cc_ready, cc_number, cc_value}, 31'd0);
        step(0, 1, 8'h02);
        chk("hs_cc_a", {15'd0, note_ready, cc_ready, cc_number, cc_value}, {15'd0, 1'b0, 1'b1, 7'd1, 7'd2});
        step(0, 1, 8'h03);
        chk("hs_cc_gap", {15'd0, note_ready, cc_ready, cc_number, cc_value}, {15'd0, 1'b0, 1'b0, 7'd1, 7'd2});
        step(0, 1, 8'h04);
        chk("hs_cc_b", {15'd0, note_ready, cc_ready, cc_number, cc_value}, {15'd0, 1'b0, 1'b1, 7'd3, 7'd4});
        step(0, 0, 8'h00);
        chk("hs_cc_hold", {15'd0, note_ready, cc_ready, cc_number, cc_value}, {15'd0, 1'b0, 1'b0, 7'd3, 7'd4});
        step(0, 1, 8'hE0);
        step(0, 1, 8'h00);
        step(0, 1, 8'h40);
        chk("hs_bend_silent", {note_ready, note, cc_ready, cc_number, cc_value},
            {1'b0, 15'd0, 1'b0, 7'd3, 7'd4});
        step(0, 0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
